// File: rtl/bulls_cows_engine.sv
// Bulls-and-cows (1A2B) game engine: LFSR secret generation, guess validation,
// sequential A/B scoring, and win/lose tracking over a valid/ready guess port.
module bulls_cows_engine #(
  parameter int          NUM_DIGITS = 4,
  parameter int          DIGIT_W    = 4,
  parameter int          BASE       = 10,
  parameter int          MAX_TRIES  = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hFF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       guess,
  input  logic                                guess_valid,
  output logic                                guess_ready,
  output logic                                result_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     a_count,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     b_count,
  output logic                                input_error,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_used,
  output logic                                win,
  output logic                                lose,
  output logic                                busy,
  output logic [NUM_DIGITS*DIGIT_W-1:0]       secret_out
);

  localparam int CNT_W = $clog2(NUM_DIGITS+1);
  localparam int TRY_W = $clog2(MAX_TRIES+1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS-1);
  localparam logic [7:0]       BASE_8    = 8'(BASE);
  localparam logic [CNT_W-1:0] FULL_A    = CNT_W'(NUM_DIGITS);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [DIGIT_W:0] BASE_X    = (DIGIT_W+1)'(BASE);

  // SCORE is the scoring half of the externally visible CHECK phase
  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_CHECK, S_SCORE, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [7:0]         lfsr, cand8;
  logic [DIGIT_W-1:0] cand;
  logic [DIGIT_W-1:0] sec [NUM_DIGITS];
  logic [DIGIT_W-1:0] g   [NUM_DIGITS];
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   acc_a, acc_b, next_a, next_b;
  logic [TRY_W-1:0]   tries_inc;
  logic               gen_dup, guess_bad, hit_a, hit_b, last;

  assign cand8     = lfsr % BASE_8;
  assign cand      = cand8[DIGIT_W-1:0];
  assign last      = (idx == LAST_IDX);
  assign tries_inc = tries_used + TRY_W'(1);

  always_comb begin
    gen_dup = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++)
      if (IDX_W'(j) < idx && sec[j] == cand) gen_dup = 1'b1;
  end

  always_comb begin
    guess_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ({1'b0, g[i]} >= BASE_X) guess_bad = 1'b1;
      for (int unsigned j = i + 1; j < NUM_DIGITS; j++)
        if (g[i] == g[j]) guess_bad = 1'b1;
    end
  end

  always_comb begin
    hit_a = (g[idx] == sec[idx]);
    hit_b = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++)
      if (g[idx] == sec[j]) hit_b = 1'b1;
    hit_b  = hit_b & ~hit_a;
    next_a = acc_a + CNT_W'(hit_a);
    next_b = acc_b + CNT_W'(hit_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_GEN;
      S_GEN:          if (!gen_dup && last) state_nxt = S_WAIT;
      S_WAIT:         if (guess_valid) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = guess_bad ? S_WAIT : S_SCORE;
      S_SCORE:
        if (last) begin
          if (next_a == FULL_A || tries_inc == TRY_LIMIT) state_nxt = S_DONE;
          else                                            state_nxt = S_WAIT;
        end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    guess_ready = (state == S_WAIT);
    busy        = (state == S_GEN) || (state == S_CHECK) || (state == S_SCORE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr         <= LFSR_SEED;
      idx          <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      result_valid <= 1'b0;
      a_count      <= '0;
      b_count      <= '0;
      input_error  <= 1'b0;
      tries_used   <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        sec[i] <= '0;
        g[i]   <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            idx         <= '0;
            a_count     <= '0;
            b_count     <= '0;
            input_error <= 1'b0;
            tries_used  <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) sec[i] <= '0;
          end
        S_GEN: begin
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          if (!gen_dup) begin
            sec[idx] <= cand;
            idx      <= last ? '0 : idx + IDX_W'(1);
          end
        end
        S_WAIT:
          if (guess_valid)
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
              g[i] <= guess[i*DIGIT_W +: DIGIT_W];
        S_CHECK:
          if (guess_bad) begin
            result_valid <= 1'b1;
            input_error  <= 1'b1;
            a_count      <= '0;
            b_count      <= '0;
          end else begin
            acc_a <= '0;
            acc_b <= '0;
            idx   <= '0;
          end
        S_SCORE: begin
          acc_a <= next_a;
          acc_b <= next_b;
          idx   <= last ? '0 : idx + IDX_W'(1);
          if (last) begin
            result_valid <= 1'b1;
            input_error  <= 1'b0;
            a_count      <= next_a;
            b_count      <= next_b;
            tries_used   <= tries_inc;
            win          <= (next_a == FULL_A);
            lose         <= (next_a != FULL_A) && (tries_inc == TRY_LIMIT);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    secret_out = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      secret_out[i*DIGIT_W +: DIGIT_W] = sec[i];
  end

endmodule
